// File: rtl/mmu_tile_sequencer.sv
// Per-tile sequencer for the weight-stationary systolic MMU.
// Loads weights, activates them, streams activations and paces result writes.
module mmu_tile_sequencer #(
    parameter int MATRIX_WIDTH   = 14,
    parameter int ADDR_WIDTH     = 16,
    parameter int ROW_WIDTH      = 16,
    parameter int RESULT_LATENCY = 30
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_weight_addr,
    input  logic [ADDR_WIDTH-1:0] cmd_act_addr,
    input  logic [ADDR_WIDTH-1:0] cmd_res_addr,
    input  logic [ROW_WIDTH-1:0]  cmd_rows,
    input  logic                  cmd_weight_signed,
    input  logic                  cmd_act_signed,
    output logic                  wbuf_rd_en,
    output logic [ADDR_WIDTH-1:0] wbuf_rd_addr,
    output logic                  abuf_rd_en,
    output logic [ADDR_WIDTH-1:0] abuf_rd_addr,
    output logic                  mmu_enable,
    output logic                  mmu_load_weight,
    output logic [7:0]            mmu_weight_address,
    output logic                  mmu_weight_signed,
    output logic                  mmu_activate_weight,
    output logic                  mmu_systolic_signed,
    output logic                  res_wr_en,
    output logic [ADDR_WIDTH-1:0] res_wr_addr,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        LOAD_TAIL,
        ACTIVATE,
        COMPUTE,
        DRAIN
    } state_e;

    state_e                    state_q;
    logic [7:0]                k_q;
    logic [7:0]                ld_idx_q;
    logic [ROW_WIDTH-1:0]      r_q;
    logic [ROW_WIDTH-1:0]      rows_q;
    logic [ADDR_WIDTH-1:0]     wbase_q;
    logic [ADDR_WIDTH-1:0]     abase_q;
    logic [ADDR_WIDTH-1:0]     waddr_q;
    logic [ADDR_WIDTH-1:0]     waddr_d;
    logic                      wsig_q;
    logic                      asig_q;
    logic                      ld_q;
    logic                      sys_q;
    logic                      done_q;
    logic [RESULT_LATENCY-1:0] pipe_q;
    logic [RESULT_LATENCY-1:0] pipe_d;
    logic                      accept;

    assign cmd_ready  = (state_q == IDLE);
    assign accept     = cmd_valid & cmd_ready;
    assign wbuf_rd_en = (state_q == LOAD);
    assign abuf_rd_en = (state_q == COMPUTE);

    assign wbuf_rd_addr = wbuf_rd_en
                        ? wbase_q + ADDR_WIDTH'(k_q) : '0;
    assign abuf_rd_addr = abuf_rd_en
                        ? abase_q + ADDR_WIDTH'(r_q) : '0;

    assign mmu_enable          = (state_q != IDLE);
    assign mmu_load_weight     = ld_q;
    assign mmu_weight_address  = ld_idx_q;
    assign mmu_weight_signed   = wsig_q &
                                 ((state_q == LOAD) |
                                  (state_q == LOAD_TAIL));
    assign mmu_activate_weight = (state_q == ACTIVATE);
    assign mmu_systolic_signed = sys_q;

    assign res_wr_en   = pipe_q[RESULT_LATENCY-1];
    assign res_wr_addr = res_wr_en ? waddr_q : '0;
    assign busy        = mmu_enable | done_q;
    assign done        = done_q;

    // Bit i set means an activation read happened i+1 cycles ago.
    always_comb begin
        pipe_d  = {pipe_q[RESULT_LATENCY-2:0], abuf_rd_en};
        waddr_d = waddr_q;
        if (accept) begin
            waddr_d = cmd_res_addr;
        end else if (res_wr_en) begin
            waddr_d = waddr_q + ADDR_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            k_q      <= '0;
            ld_idx_q <= '0;
            r_q      <= '0;
            rows_q   <= '0;
            wbase_q  <= '0;
            abase_q  <= '0;
            waddr_q  <= '0;
            wsig_q   <= 1'b0;
            asig_q   <= 1'b0;
            ld_q     <= 1'b0;
            sys_q    <= 1'b0;
            done_q   <= 1'b0;
            pipe_q   <= '0;
        end else begin
            done_q   <= 1'b0;
            ld_q     <= wbuf_rd_en;
            ld_idx_q <= wbuf_rd_en ? k_q : '0;
            sys_q    <= abuf_rd_en & asig_q;
            pipe_q   <= pipe_d;
            waddr_q  <= waddr_d;
            unique case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        wbase_q <= cmd_weight_addr;
                        abase_q <= cmd_act_addr;
                        rows_q  <= cmd_rows;
                        wsig_q  <= cmd_weight_signed;
                        asig_q  <= cmd_act_signed;
                        k_q     <= '0;
                        r_q     <= '0;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    k_q <= k_q + 8'd1;
                    if (k_q == 8'(MATRIX_WIDTH - 1)) begin
                        state_q <= LOAD_TAIL;
                    end
                end
                LOAD_TAIL: state_q <= ACTIVATE;
                ACTIVATE: begin
                    // Empty tile has nothing to drain: finish now.
                    if (rows_q == '0) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    r_q <= r_q + ROW_WIDTH'(1);
                    if (r_q == rows_q - ROW_WIDTH'(1)) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pipe_q[RESULT_LATENCY-2:0] == '0) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
